uart_avm_slave: RTL
===================

UART_AVM_SLAVE -- requirements
Module: uart_avm_slave

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning avm_clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line rate in bit/s.
REQ-003 SHALL have port avm_clk  input  1  clock.
REQ-004 SHALL have port avm_rst  input  1  reset: avm_rst, asynchronous, active-high; clock avm_clk.
REQ-005 SHALL have port avs_address  input  5  byte offset: 0 RX data, 4 TX data, 8 status.
REQ-006 SHALL have port avs_read  input  1  read request.
REQ-007 SHALL have port avs_readdata  output  32  read data, valid when avs_waitrequest low.
REQ-008 SHALL have port avs_write  input  1  write request.
REQ-009 SHALL have port avs_writedata  input  32  write data; bits [7:0] used.
REQ-010 SHALL have port avs_waitrequest  output  1  stall current access.
REQ-011 SHALL have port uart_rxd  input  1  serial in, asynchronous to avm_clk.
REQ-012 SHALL have port uart_txd  output  1  serial out, idle high.

Function
REQ-013 SHALL use DIV = round(CLK_HZ/BAUD) clocks per bit (434 at defaults); 8N1 frames, LSB first.
REQ-014 SHALL complete every access with exactly one wait state: waitrequest high in first cycle of read/write, low in second; side effects occur once, in the low cycle.
REQ-015 SHALL, when avs_read and avs_write both asserted, perform the read and ignore the write.
REQ-016 SHALL return status at offset 8: bit7 rx_ready, bit6 tx_ready, bit3 overrun, bit2 frame_err, other bits 0; status read clears bits 3 and 2.
REQ-017 SHALL return {24'b0, rx_byte} at offset 0 and clear rx_ready; read while rx_ready=0 returns last byte, no side effect.
REQ-018 SHALL, on write to offset 4 with tx_ready=1, load writedata[7:0] and start transmission; tx_ready drops on the completing cycle.
REQ-019 SHALL ignore TX writes while tx_ready=0 (byte dropped, no flag).
REQ-020 SHALL return 0 for reads of unmapped offsets and ignore writes to them, still with one wait state.
REQ-021 SHALL pass uart_rxd through a 2-flop synchronizer before use.
REQ-022 SHALL run RX FSM R_IDLE -> R_START on falling edge; R_START re-samples at DIV/2, high -> R_IDLE (glitch), low -> R_DATA; R_DATA samples 8 bits every DIV clocks; R_STOP samples once, then R_IDLE.
REQ-023 SHALL, at R_STOP sample high, store byte and set rx_ready; sample low sets frame_err and discards byte.
REQ-024 SHALL, if a byte completes while rx_ready=1 and storage full, drop the new byte and set overrun (sticky).
REQ-025 SHALL, if a byte completes in the same cycle an RX-data read completes, return the old byte, store the new byte, keep rx_ready=1, not set overrun.
REQ-026 SHALL run TX FSM T_IDLE -> T_START -> T_DATA(8 bits) -> T_STOP, each bit DIV clocks; tx_ready=1 only in T_IDLE.

Reset
REQ-027 SHALL on avm_rst drive uart_txd=1, avs_waitrequest=0, avs_readdata=0, FSMs idle, rx_ready=0, overrun=0, frame_err=0, counters 0.
REQ-028 SHALL abort any frame in progress on reset mid-operation; uart_txd goes high asynchronously.

Configuration
REQ-029 SHALL, with UART_RX_FIFO_EN defined, buffer RX in an 8-entry FIFO: rx_ready = not empty, overrun only when full, RX read pops.
REQ-030 SHALL, without UART_RX_FIFO_EN, use a single holding register as per REQ-017..025.

Structure
REQ-031 SHALL place offsets (0,4,8), status bit positions (7,6,3,2), RX/TX state enums and DIV computation in package uart_avm_pkg.
REQ-032 SHALL implement receiver (synchronizer, RX FSM, bit counter) as sub-module uart_rx.

Verification
REQ-033 SHALL check reset: status read -> 0x40, uart_txd=1, rx read -> 0x00.
REQ-034 SHALL check RX: drive byte 0xA5 at 115200 -> status 0xC0; RX read -> 0x000000A5; status then 0x40.
REQ-035 SHALL check TX: write 0x3C -> uart_txd start bit then 0,0,1,1,1,1,0,0, stop, 434 clocks each; status 0x00 during, 0x40 after.
REQ-036 SHALL check overrun: send 0x11 then 0x22 unread -> status 0xC8, RX read 0x11 (FIFO build: 0x11 then 0x22, no overrun until 9th byte).
REQ-037 SHALL check frame error: byte 0x55 with stop bit low -> status 0x44, rx_ready=0; glitch of 100 clocks low on rxd -> no byte.
REQ-038 SHALL check wait state and REQ-025: every access waitrequest high exactly 1 cycle; RX-read coinciding with stop-bit sample returns old byte, status 0xC0 after.

Source files
------------

// File: rtl/uart_avm_pkg.sv
// Shared definitions for the UART Avalon-MM slave: register map, status bit
// positions, receiver/transmitter state encodings and the baud divider.
package uart_avm_pkg;

    // Register byte offsets
    localparam logic [4:0] OFS_RX     = 5'd0;
    localparam logic [4:0] OFS_TX     = 5'd4;
    localparam logic [4:0] OFS_STATUS = 5'd8;

    // Status register bit positions
    localparam int ST_RX_READY  = 7;
    localparam int ST_TX_READY  = 6;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_FRAME_ERR = 2;

    // Receive buffer depth when the optional FIFO is built in
    localparam int RX_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } tx_state_t;

    // Clocks per bit, rounded to the nearest integer
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: input synchronizer, start-bit qualification, 8N1 sampling.
// byte_done / frame_err are single-cycle strobes issued in the stop-bit
// sampling cycle; data holds the assembled byte while byte_done is high.
module uart_rx
    import uart_avm_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       avm_clk,
    input  logic       avm_rst,
    input  logic       rxd,
    output logic       byte_done,
    output logic       frame_err,
    output logic [7:0] data
);

    localparam int              CNT_W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);

    logic             rxd_meta;
    logic             rxd_sync;
    logic             rxd_prev;
    rx_state_t        state;
    rx_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_cnt_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // Receiver state, bit timer, bit counter and shift register
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state   <= R_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
        end
    end

    // Next-state logic: mid-bit sampling, glitch rejection, stop-bit check
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        byte_done    = 1'b0;
        frame_err    = 1'b0;
        case (state)
            R_IDLE: begin
                cnt_next     = '0;
                bit_cnt_next = '0;
                if (rxd_prev && !rxd_sync) begin
                    state_next = R_START;
                end
            end
            R_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_next   = '0;
                    state_next = rxd_sync ? R_IDLE : R_DATA;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            R_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rxd_sync, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = R_STOP;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            R_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = R_IDLE;
                    if (rxd_sync) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = R_IDLE;
        endcase
    end

    assign data = shift;

endmodule

// File: rtl/uart_avm_slave.sv
// UART with an Avalon-MM slave register interface (RX data, TX data, status).
// Every access takes exactly one wait state; side effects happen in the
// completing cycle. Build option UART_RX_FIFO_EN replaces the single RX
// holding register with an 8-entry receive FIFO.
module uart_avm_slave
    import uart_avm_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int               DIV      = uart_div(CLK_HZ, BAUD);
    localparam int               CNT_W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic       pend;
    logic       access;
    logic       done;
    logic       rd_done;
    logic       wr_done;
    logic       rd_rx;
    logic       rd_status;
    logic       wr_tx;
    logic [7:0] status;

    logic       rx_byte_done;
    logic       rx_frame_err;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] rx_head;
    logic       rx_overflow;
    logic       overrun;
    logic       frame_err;

    tx_state_t        tx_state;
    tx_state_t        tx_state_next;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] tx_cnt_next;
    logic [2:0]       tx_bit;
    logic [2:0]       tx_bit_next;
    logic [7:0]       tx_shift;
    logic [7:0]       tx_shift_next;
    logic             txd_next;
    logic             tx_ready;
    logic             unused_wdata;

    assign unused_wdata = ^avs_writedata[31:8];

    // ---------------------------------------------------------------------
    // Bus handshake: first cycle of a request stalls, second one completes
    // ---------------------------------------------------------------------
    assign access          = avs_read | avs_write;
    assign avs_waitrequest = access & ~pend & ~avm_rst;
    assign done            = access & pend;
    assign rd_done         = done & avs_read;
    assign wr_done         = done & avs_write & ~avs_read;
    assign rd_rx           = rd_done && (avs_address == OFS_RX);
    assign rd_status       = rd_done && (avs_address == OFS_STATUS);
    assign wr_tx           = wr_done && (avs_address == OFS_TX);

    // Wait-state phase flag: set in the stall cycle, cleared on completion
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            pend <= 1'b0;
        end else if (pend) begin
            pend <= 1'b0;
        end else if (access) begin
            pend <= 1'b1;
        end
    end

    // Status word assembly
    always_comb begin
        status               = '0;
        status[ST_RX_READY]  = rx_ready;
        status[ST_TX_READY]  = tx_ready;
        status[ST_OVERRUN]   = overrun;
        status[ST_FRAME_ERR] = frame_err;
    end

    // Read data mux, driven only in the completing cycle of a read
    always_comb begin
        avs_readdata = '0;
        if (rd_done) begin
            case (avs_address)
                OFS_RX:     avs_readdata = {24'b0, rx_head};
                OFS_STATUS: avs_readdata = {24'b0, status};
                default:    avs_readdata = '0;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Receive path
    // ---------------------------------------------------------------------
    uart_rx #(
        .DIV (DIV)
    ) u_rx (
        .avm_clk   (avm_clk),
        .avm_rst   (avm_rst),
        .rxd       (uart_rxd),
        .byte_done (rx_byte_done),
        .frame_err (rx_frame_err),
        .data      (rx_data)
    );

`ifdef UART_RX_FIFO_EN
    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);

    logic [7:0]     fifo_mem [RX_FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [7:0]     rx_last;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                         (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
    assign pop         = rd_rx & ~fifo_empty;
    assign push        = rx_byte_done & (~fifo_full | pop);
    assign rx_overflow = rx_byte_done & fifo_full & ~pop;
    assign rx_ready    = ~fifo_empty;
    assign rx_head     = fifo_empty ? rx_last : fifo_mem[rd_ptr[PTR_W-1:0]];

    // FIFO pointers and the last popped byte (returned when empty)
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rx_last <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rx_last <= fifo_mem[rd_ptr[PTR_W-1:0]];
            end
        end
    end

    // FIFO storage array
    always_ff @(posedge avm_clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= rx_data;
        end
    end
`else
    logic [7:0] rx_hold;
    logic       rx_full;

    assign rx_ready    = rx_full;
    assign rx_head     = rx_hold;
    assign rx_overflow = rx_byte_done & rx_full & ~rd_rx;

    // Single holding register; a read completing with a new byte hands over
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rx_hold <= '0;
            rx_full <= 1'b0;
        end else if (rx_byte_done && (!rx_full || rd_rx)) begin
            rx_hold <= rx_data;
            rx_full <= 1'b1;
        end else if (rd_rx) begin
            rx_full <= 1'b0;
        end
    end
`endif

    // Sticky error flags; a new error wins over a same-cycle status clear
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_overflow) begin
                overrun <= 1'b1;
            end else if (rd_status) begin
                overrun <= 1'b0;
            end
            if (rx_frame_err) begin
                frame_err <= 1'b1;
            end else if (rd_status) begin
                frame_err <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Transmit path
    // ---------------------------------------------------------------------
    assign tx_ready = (tx_state == T_IDLE);

    // Transmitter state, bit timer and serial output register
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_bit   <= tx_bit_next;
            tx_shift <= tx_shift_next;
            uart_txd <= txd_next;
        end
    end

    // Next-state logic; line level is derived from the state being entered
    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        case (tx_state)
            T_IDLE: begin
                tx_cnt_next = '0;
                tx_bit_next = '0;
                if (wr_tx) begin
                    tx_shift_next = avs_writedata[7:0];
                    tx_state_next = T_START;
                end
            end
            T_START: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_state_next = T_DATA;
                end else begin
                    tx_cnt_next = tx_cnt + 1'b1;
                end
            end
            T_DATA: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = tx_bit + 3'd1;
                    tx_shift_next = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) begin
                        tx_state_next = T_STOP;
                    end
                end else begin
                    tx_cnt_next = tx_cnt + 1'b1;
                end
            end
            T_STOP: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_state_next = T_IDLE;
                end else begin
                    tx_cnt_next = tx_cnt + 1'b1;
                end
            end
            default: tx_state_next = T_IDLE;
        endcase

        case (tx_state_next)
            T_START: txd_next = 1'b0;
            T_DATA:  txd_next = tx_shift_next[0];
            default: txd_next = 1'b1;
        endcase
    end

endmodule
